// File: rtl/te_smooth_filter_pipe.sv
// Two-stage 3x3 smoothing filter (full / horizontal / vertical / passthrough) with valid-ready flow control.
// Optional macro TE_SMOOTH_ROUND_EN: round-half-up before the final shift instead of truncating.
module te_smooth_filter_pipe #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    input  logic [DATA_W-1:0] in8,
    input  logic [DATA_W-1:0] in9,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_cnt
);

    // Partial sums weigh up to 4x a pixel, the full sum up to 16x.
    localparam int PW = DATA_W + 2;
    localparam int SW = DATA_W + 4;

    localparam logic [1:0] MODE_FULL = 2'b00;
    localparam logic [1:0] MODE_HORZ = 2'b01;
    localparam logic [1:0] MODE_VERT = 2'b10;

`ifdef TE_SMOOTH_ROUND_EN
    localparam logic [SW-1:0] RND_FULL = SW'(8);
    localparam logic [PW-1:0] RND_TRI  = PW'(2);
`else
    localparam logic [SW-1:0] RND_FULL = '0;
    localparam logic [PW-1:0] RND_TRI  = '0;
`endif

    logic              s1_valid;
    logic [PW-1:0]     s1_p0;
    logic [PW-1:0]     s1_p1;
    logic [PW-1:0]     s1_p2;
    logic [1:0]        s1_mode;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic [CNT_W-1:0]  cnt;

    logic              s2_load;
    logic              s1_advance;
    logic              accept;
    logic              complete;

    logic [PW-1:0]     row1;
    logic [PW-1:0]     row2;
    logic [PW-1:0]     row3;
    logic [PW-1:0]     col2;
    logic [PW-1:0]     p0_next;
    logic [PW-1:0]     p1_next;
    logic [PW-1:0]     p2_next;
    logic [SW-1:0]     full_sum;
    logic [PW-1:0]     tri_sum;
    logic [DATA_W-1:0] result;

    assign s2_load    = !s2_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = !rst && (!s1_valid || s1_advance);
    assign accept     = in_valid && in_ready;
    assign complete   = s2_valid && out_ready;

    assign out_valid  = s2_valid;
    assign out_data   = s2_data;
    assign out_cnt    = cnt;

    always_comb begin
        row1 = PW'(in1) + (PW'(in2) << 1) + PW'(in3);
        row2 = PW'(in4) + (PW'(in5) << 1) + PW'(in6);
        row3 = PW'(in7) + (PW'(in8) << 1) + PW'(in9);
        col2 = PW'(in2) + (PW'(in5) << 1) + PW'(in8);

        // p1 carries the only term the reduced modes need; p0/p2 matter only in full mode.
        p0_next = '0;
        p2_next = '0;
        case (mode)
            MODE_FULL: begin
                p0_next = row1;
                p1_next = row2;
                p2_next = row3;
            end
            MODE_HORZ: p1_next = row2;
            MODE_VERT: p1_next = col2;
            default:   p1_next = PW'(in5);
        endcase
    end

    always_comb begin
        full_sum = SW'(s1_p0) + (SW'(s1_p1) << 1) + SW'(s1_p2) + RND_FULL;
        tri_sum  = s1_p1 + RND_TRI;
        case (s1_mode)
            MODE_FULL: result = DATA_W'(full_sum >> 4);
            MODE_HORZ,
            MODE_VERT: result = DATA_W'(tri_sum >> 2);
            default:   result = DATA_W'(s1_p1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_p0   <= p0_next;
            s1_p1   <= p1_next;
            s1_p2   <= p2_next;
            s1_mode <= mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            cnt      <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= result;
                end
            end
            if (complete) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_te_smooth_filter_pipe.sv
// Self-checking bench for te_smooth_filter_pipe: directed scenarios plus a randomized stream against a formula model.
module tb_te_smooth_filter_pipe;

`ifdef TE_SMOOTH_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  win [1:9];
    logic [1:0]  mode = 2'b00;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [15:0] out_cnt;
    logic        b_in_ready;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic [3:0]  b_out_cnt;

    int total = 0;
    int bad = 0;
    int hold_err = 0;
    int hs_total = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    te_smooth_filter_pipe #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in1(win[1]), .in2(win[2]), .in3(win[3]), .in4(win[4]), .in5(win[5]),
        .in6(win[6]), .in7(win[7]), .in8(win[8]), .in9(win[9]),
        .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt)
    );

    te_smooth_filter_pipe #(.DATA_W(8), .CNT_W(4)) dut_cnt4 (
        .clk(clk), .rst(rst),
        .in1(win[1]), .in2(win[2]), .in3(win[3]), .in4(win[4]), .in5(win[5]),
        .in6(win[6]), .in7(win[7]), .in8(win[8]), .in9(win[9]),
        .mode(mode), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_cnt(b_out_cnt)
    );

    // Kernel weights are the outer product of [1 2 1] with itself; reduced kernels use one line of it.
    function automatic logic [7:0] ref_out(input logic [1:0] m, input logic [7:0] w [1:9]);
        int s;
        int sh;
        s = 0;
        sh = 2;
        case (m)
            2'd0: begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        s += int'(w[r*3+c+1]) * ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
                sh = 4;
            end
            2'd1: s = int'(w[4]) + 2 * int'(w[5]) + int'(w[6]);
            2'd2: s = int'(w[2]) + 2 * int'(w[5]) + int'(w[8]);
            default: return w[5];
        endcase
        if (ROUND) s += 1 << (sh - 1);
        return 8'(s >> sh);
    endfunction

    task automatic randomize_window();
        for (int i = 1; i <= 9; i++) win[i] = 8'($urandom_range(0, 255));
    endtask

    // Called just after a falling edge; records handshakes for the coming rising edge.
    task automatic step(output bit acc, output bit done);
        logic [7:0] w [1:9];
        #1;
        acc = 1'b0;
        done = 1'b0;
        if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) hold_err++;
        if (!rst) begin
            if (out_valid && out_ready) begin
                done = 1'b1;
                got_q.push_back(out_data);
                hs_total++;
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                for (int i = 1; i <= 9; i++) w[i] = win[i];
                exp_q.push_back(ref_out(mode, w));
            end
        end else begin
            hs_total = 0;
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_data = out_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bit a, d;
        rst = 1'b1;
        in_valid = 1'b0;
        step(a, d);
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        bit a, d;
        rst = 1'b1;
        step(a, d);
        step(a, d);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        total++; if (out_cnt !== 16'd0) begin bad++; $display("FAIL reset_out_cnt got=%0d want=0", out_cnt); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_full_basic();
        bit a, d;
        do_reset();
        for (int i = 1; i <= 9; i++) win[i] = 8'd100;
        mode = 2'b00;
        out_ready = 1'b1;
        in_valid = 1'b1;
        step(a, d);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", out_valid); end
        step(a, d);
        total++; if (out_valid !== 1'b1 || out_data !== 8'd100)
            begin bad++; $display("FAIL full_100 got=%b/%0d want=1/100", out_valid, out_data); end
        step(a, d);
        total++; if (out_cnt !== 16'd1) begin bad++; $display("FAIL full_100_cnt got=%0d want=1", out_cnt); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_impulse();
        bit a, d;
        logic [7:0] want;
        want = ROUND ? 8'd64 : 8'd63;
        do_reset();
        for (int i = 1; i <= 9; i++) win[i] = 8'd0;
        win[5] = 8'd255;
        mode = 2'b00;
        out_ready = 1'b1;
        in_valid = 1'b1;
        step(a, d);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step(a, d);
        total++; if (got_q.size() != 1 || got_q[0] !== want)
            begin bad++; $display("FAIL impulse got_n=%0d got=%0d want=%0d", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'd0, want); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_modes();
        bit a, d;
        int n_acc;
        do_reset();
        out_ready = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 4; k++) begin
            randomize_window();
            mode = 2'(k);
            if (k == 1) begin win[4] = 8'd0; win[5] = 8'd100; win[6] = 8'd200; end
            if (k == 2) begin win[2] = 8'd10; win[5] = 8'd20; win[8] = 8'd30; end
            in_valid = 1'b1;
            step(a, d);
            if (a) n_acc++;
        end
        in_valid = 1'b0;
        mode = 2'b00;
        for (int k = 0; k < 4; k++) step(a, d);
        total++; if (n_acc != 4) begin bad++; $display("FAIL modes_throughput got=%0d want=4", n_acc); end
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL modes_count got=%0d want=4", got_q.size()); end
        if (got_q.size() == 4) begin
            total++; if (got_q[1] !== 8'd100) begin bad++; $display("FAIL mode_horz got=%0d want=100", got_q[1]); end
            total++; if (got_q[2] !== 8'd20) begin bad++; $display("FAIL mode_vert got=%0d want=20", got_q[2]); end
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL modes_data got=%0d want=%0d", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit a, d;
        int n_acc, n_done, cnt0;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            randomize_window();
            mode = 2'($urandom_range(0, 3));
            step(a, d);
            if (a) n_acc++;
        end
        total++; if (n_acc != 2) begin bad++; $display("FAIL bp_accepts got=%0d want=2", n_acc); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt0 = int'(out_cnt);
        n_done = 0;
        for (int k = 0; k < 2; k++) begin
            step(a, d);
            if (d) n_done++;
        end
        total++; if (n_done != 2) begin bad++; $display("FAIL bp_one_per_clock got=%0d want=2", n_done); end
        total++; if (int'(out_cnt) != cnt0 + 2) begin bad++; $display("FAIL bp_cnt got=%0d want=%0d", out_cnt, cnt0 + 2); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL bp_order got=%0d want=%0d", g, e); end
        end
        total++; if (hold_err != 0) begin bad++; $display("FAIL bp_hold got=%0d want=0", hold_err); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        bit a, d;
        int n_done;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        randomize_window();
        step(a, d);
        in_valid = 1'b0;
        step(a, d);
        step(a, d);
        out_ready = 1'b0;
        in_valid = 1'b1;
        step(a, d);
        step(a, d);
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
            begin bad++; $display("FAIL midrst_full got=%b/%b want=0/1", in_ready, out_valid); end
        rst = 1'b1;
        step(a, d);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        total++; if (out_cnt !== 16'd0 || b_out_cnt !== 4'd0)
            begin bad++; $display("FAIL midrst_cnt got=%0d/%0d want=0/0", out_cnt, b_out_cnt); end
        rst = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        exp_q.delete();
        n_done = 0;
        for (int k = 0; k < 5; k++) begin
            step(a, d);
            if (d) n_done++;
        end
        total++; if (n_done != 0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", n_done); end
        got_q.delete();
    endtask

    task automatic test_random();
        bit a, d;
        int guard;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            randomize_window();
            mode = 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 99) < 65);
            out_ready = ($urandom_range(0, 99) < 70);
            step(a, d);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 10) begin
            step(a, d);
            guard++;
        end
        total++; if (got_q.size() != exp_q.size())
            begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        total++; if (int'(out_cnt) != hs_total) begin bad++; $display("FAIL rand_cnt got=%0d want=%0d", out_cnt, hs_total); end
        total++; if (hold_err != 0) begin bad++; $display("FAIL rand_hold got=%0d want=0", hold_err); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL rand_data got=%0d want=%0d", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_cnt_wrap();
        bit a, d;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            randomize_window();
            mode = 2'($urandom_range(0, 3));
            step(a, d);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step(a, d);
        total++; if (b_out_cnt !== 4'd1) begin bad++; $display("FAIL cnt4_wrap got=%0d want=1", b_out_cnt); end
        total++; if (out_cnt !== 16'd17) begin bad++; $display("FAIL cnt16 got=%0d want=17", out_cnt); end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        for (int i = 1; i <= 9; i++) win[i] = 8'd0;
        @(negedge clk);
        test_reset();
        test_full_basic();
        test_impulse();
        test_modes();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
